event_gap_monitor: RTL and testbench

- Downstream consumer of single-cycle event pulses produced by a handshake/liveness FSM (e.g. its flag or live output).
- Measures cycles between consecutive events, tracks the worst-case gap and an event count, and raises a sticky timeout when no event arrives within MAX_GAP cycles.
- Serves as the bounded-liveness companion used alongside unbounded s_eventually properties in property-support regressions.
- Carries its own embedded SVA assertions.

---
 rtl/event_gap_monitor.sv | 138 +++++++++++++
 tb/tb_event_gap_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/event_gap_monitor.sv
// Event gap monitor: times the spacing of single-cycle event pulses,
// tracks the worst inter-event gap and latches a sticky timeout fault.
module event_gap_monitor #(
   parameter int GAP_W   = 8,
   parameter int MAX_GAP = 20,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             ev,
   output logic [1:0]       state,
   output logic [GAP_W-1:0] gap,
   output logic [GAP_W-1:0] max_gap,
   output logic [CNT_W-1:0] ev_count,
   output logic             cnt_sat,
   output logic             timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_TRACK = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [GAP_W-1:0] LP_LAST = GAP_W'(MAX_GAP - 1);
   localparam logic [GAP_W-1:0] LP_MAX  = GAP_W'(MAX_GAP);
   localparam logic [CNT_W-1:0] LP_SAT  = '1;

   generate
      if ((MAX_GAP < 1) || (MAX_GAP > (2 ** GAP_W) - 1)) begin : g_bad_max_gap
         $error("event_gap_monitor: MAX_GAP out of range for GAP_W");
      end
   endgenerate

   state_t           r_state;
   logic [GAP_W-1:0] r_gap;
   logic [GAP_W-1:0] r_max_gap;
   logic [CNT_W-1:0] r_ev_count;
   logic             r_cnt_sat;
   logic             r_timeout;

   state_t           w_state_nxt;
   logic [GAP_W-1:0] w_gap_nxt;
   logic [GAP_W-1:0] w_max_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_sat_nxt;
   logic             w_tout_nxt;
   logic             w_accept;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_state    <= S_IDLE;
         r_gap      <= '0;
         r_max_gap  <= '0;
         r_ev_count <= '0;
         r_cnt_sat  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap      <= w_gap_nxt;
         r_max_gap  <= w_max_nxt;
         r_ev_count <= w_cnt_nxt;
         r_cnt_sat  <= w_sat_nxt;
         r_timeout  <= w_tout_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      w_max_nxt   = r_max_gap;
      w_tout_nxt  = r_timeout;
      w_accept    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (en) begin
               w_state_nxt = S_ARMED;
               w_gap_nxt   = '0;
            end
         end
         S_ARMED, S_TRACK: begin
            if (!en) begin
               w_state_nxt = S_IDLE;
               w_gap_nxt   = '0;
            end else if (ev) begin
               w_state_nxt = S_TRACK;
               w_gap_nxt   = '0;
               w_accept    = 1'b1;
               // the arming wait is not an inter-event gap
               if ((r_state == S_TRACK) && (r_gap > r_max_gap))
                  w_max_nxt = r_gap;
            end else if (r_gap == LP_LAST) begin
               w_state_nxt = S_FAULT;
               w_gap_nxt   = LP_MAX;
               w_tout_nxt  = 1'b1;
            end else begin
               w_gap_nxt = r_gap + GAP_W'(1);
            end
         end
         S_FAULT: begin
            w_tout_nxt = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_cnt_nxt = r_ev_count;
      if (w_accept && (r_ev_count != LP_SAT))
         w_cnt_nxt = r_ev_count + CNT_W'(1);
      w_sat_nxt = (w_cnt_nxt == LP_SAT);
   end

   assign state    = r_state;
   assign gap      = r_gap;
   assign max_gap  = r_max_gap;
   assign ev_count = r_ev_count;
   assign cnt_sat  = r_cnt_sat;
   assign timeout  = r_timeout;

   a_tout_fault: assert property (@(posedge clk) disable iff (rst)
      r_timeout == (r_state == S_FAULT));

   a_gap_bound: assert property (@(posedge clk) disable iff (rst)
      r_gap <= LP_MAX);

   a_track_cnt: assert property (@(posedge clk) disable iff (rst)
      (r_state == S_TRACK) |-> (r_ev_count != '0));

   a_rose_tout: assert property (@(posedge clk) disable iff (rst)
      $rose(r_timeout) |-> $past(!ev));

   c_max_edge: cover property (@(posedge clk) disable iff (rst)
      (r_state == S_TRACK) && (r_max_gap == LP_LAST));

endmodule

// File: tb/tb_event_gap_monitor.sv
// Directed bench for event_gap_monitor with a queue scoreboard of
// expected output snapshots.
module tb_event_gap_monitor;

   localparam int GAP_W   = 8;
   localparam int MAX_GAP = 20;
   localparam int CNT_W   = 4;
   localparam int VW      = 2 + GAP_W + GAP_W + CNT_W + 2;

   typedef struct {
      string         tag;
      logic [VW-1:0] v;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             en;
   logic             clr;
   logic             ev;
   logic [1:0]       state;
   logic [GAP_W-1:0] gap;
   logic [GAP_W-1:0] max_gap;
   logic [CNT_W-1:0] ev_count;
   logic             cnt_sat;
   logic             timeout;

   exp_t q[$];
   int   n_chk;
   int   n_pass;

   event_gap_monitor #(
      .GAP_W  (GAP_W),
      .MAX_GAP(MAX_GAP),
      .CNT_W  (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .ev      (ev),
      .state   (state),
      .gap     (gap),
      .max_gap (max_gap),
      .ev_count(ev_count),
      .cnt_sat (cnt_sat),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input int s, input int g,
                       input int m, input int c, input int sat,
                       input int t);
      exp_t e;
      e.tag = tag;
      e.v   = {2'(s), GAP_W'(g), GAP_W'(m), CNT_W'(c), 1'(sat), 1'(t)};
      q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t          e;
      logic [VW-1:0] obs;
      obs = {state, gap, max_gap, ev_count, cnt_sat, timeout};
      n_chk++;
      if (q.size() == 0) begin
         $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.v) n_pass++;
         else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
   endtask

   task automatic cyc(input string tag, input int s, input int g,
                      input int m, input int c, input int sat,
                      input int t);
      push(tag, s, g, m, c, sat, t);
      tick();
      pop_check();
   endtask

   task automatic idle_n(input int n);
      ev = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst = 1'b1; en = 1'b0; clr = 1'b0; ev = 1'b0;
      tick();
      cyc("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      ev = 1'b1;
      cyc("idle_ignores_ev", 0, 0, 0, 0, 0, 0);
      ev = 1'b0; en = 1'b1;
      cyc("arm", 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         idle_n(3);
         ev = 1'b1;
         tick();
      end
      ev = 1'b0;
      push("gap3_x10", 2, 0, 3, 10, 0, 0);
      pop_check();

      idle_n(19);
      push("gap19_boundary", 2, 19, 3, 10, 0, 0);
      pop_check();
      ev = 1'b1;
      cyc("gap19_ontime", 2, 0, 19, 11, 0, 0);
      idle_n(19);
      push("pre_fault", 2, 19, 19, 11, 0, 0);
      pop_check();
      cyc("track_fault", 3, 20, 19, 11, 0, 1);
      ev = 1'b1; en = 1'b0;
      cyc("fault_frozen", 3, 20, 19, 11, 0, 1);

      clr = 1'b1; ev = 1'b1; en = 1'b1;
      cyc("clr_in_fault", 0, 0, 0, 0, 0, 0);
      clr = 1'b0; ev = 1'b0;
      cyc("rearm", 1, 0, 0, 0, 0, 0);
      idle_n(19);
      push("armed_gap19", 1, 19, 0, 0, 0, 0);
      pop_check();
      cyc("armed_fault", 3, 20, 0, 0, 0, 1);
      for (int i = 0; i < 50; i++) begin
         ev = i[0];
         en = (i % 3) != 0;
         if (i % 10 == 9) cyc("fault_hold", 3, 20, 0, 0, 0, 1);
         else tick();
      end

      rst = 1'b1; ev = 1'b0;
      tick();
      rst = 1'b0; en = 1'b1;
      tick();
      ev = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc("sat_run", 2, 0, 0, (i < 15) ? i : 15, (i >= 15) ? 1 : 0, 0);
      end

      rst = 1'b1; ev = 1'b0;
      tick();
      rst = 1'b0; en = 1'b1;
      tick();
      ev = 1'b1;
      tick();
      idle_n(7);
      ev = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) tick();
      idle_n(2);
      push("pre_drop", 2, 2, 7, 5, 0, 0);
      pop_check();
      en = 1'b0;
      cyc("en_drop", 0, 0, 7, 5, 0, 0);
      en = 1'b1;
      cyc("re_arm", 1, 0, 7, 5, 0, 0);
      idle_n(10);
      ev = 1'b1;
      cyc("first_ev_no_max", 2, 0, 7, 6, 0, 0);

      rst = 1'b1; ev = 1'b1;
      cyc("rst_in_track", 0, 0, 0, 0, 0, 0);
      rst = 1'b0; ev = 1'b0; en = 1'b0;
      cyc("post_rst_idle", 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
